// File: rtl/ccd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_pkg
//  Description : Shared types and default timing constants for the linear
//                CCD readout path (TCD1304-class sensor).
//                Contents:
//                  seq_state_t - readout sequencer state encoding
//                  c_*_DEF     - default timing parameters
//                  ccd_max     - constant-foldable maximum helper
//  Revision    : 1.0 - initial release
// ============================================================================
package ccd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ICG    = 2'd1,
        PIXELS = 2'd2,
        DONE   = 2'd3
    } seq_state_t;

    // Default line timing for a TCD1304-class sensor.
    localparam int unsigned c_N_PIXELS_DEF    = 3694;
    localparam int unsigned c_PIXEL_TICKS_DEF = 400;
    localparam int unsigned c_ICG_TICKS_DEF   = 500;
    localparam int unsigned c_SH_DELAY_DEF    = 100;
    localparam int unsigned c_SH_TICKS_DEF    = 200;

    function automatic int unsigned ccd_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ticker.sv
`default_nettype none
// ============================================================================
//  Module      : ticker
//  Description : Period generator. Counts enabled cycles modulo N_TICKS and
//                flags the last cycle of each period on tick.
//  Ports       : clk  - clock
//                rst  - synchronous reset, active-low
//                en   - count enable
//                tick - high on the last cycle of each N_TICKS period
//  Revision    : 1.0 - initial release
// ============================================================================
module ticker #(
    parameter int unsigned N_TICKS = 400
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned c_CNT_W = (N_TICKS > 1) ? $clog2(N_TICKS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(N_TICKS - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               w_last;

    assign w_last = (r_count == c_LAST);
    assign tick   = en && w_last;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= '0;
        end else if (en) begin
            r_count <= w_last ? '0 : r_count + c_CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ccd_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : ccd_readout_sequencer
//  Description : One-line linear CCD readout timing: ICG gate, SH shutter
//                pulse inside the ICG window, then one ADC conversion request
//                per pixel period. Conversions skipped because the ADC was
//                still busy are flagged on the sticky overrun output.
//  Ports       : clk       - clock
//                rst       - synchronous reset, active-low
//                start     - request a line readout (honoured only in IDLE)
//                adc_busy  - ADC driver busy
//                icg       - ICG gate (active-high, inverted on the board)
//                sh        - shutter gate (active-high)
//                acquire   - one-cycle conversion request
//                pix_idx   - index of the current pixel
//                busy      - line readout in progress
//                line_done - one-cycle pulse at the end of the line
//                overrun   - sticky: a conversion request was skipped
//  Revision    : 1.0 - initial release
// ============================================================================
module ccd_readout_sequencer
    import ccd_pkg::*;
#(
    parameter int unsigned N_PIXELS    = c_N_PIXELS_DEF,
    parameter int unsigned PIXEL_TICKS = c_PIXEL_TICKS_DEF,
    parameter int unsigned ICG_TICKS   = c_ICG_TICKS_DEF,
    parameter int unsigned SH_DELAY    = c_SH_DELAY_DEF,
    parameter int unsigned SH_TICKS    = c_SH_TICKS_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        adc_busy,
    output logic                        icg,
    output logic                        sh,
    output logic                        acquire,
    output logic [$clog2(N_PIXELS)-1:0] pix_idx,
    output logic                        busy,
    output logic                        line_done,
    output logic                        overrun
);

    localparam int unsigned c_TMR_W = $clog2(ccd_max(ICG_TICKS, PIXEL_TICKS) + 1);
    localparam int unsigned c_PIX_W = $clog2(N_PIXELS);

    // The ICG timer counts down from ICG_TICKS-1, so ICG-phase cycle p holds
    // timer value ICG_TICKS-1-p. SH covers timer values in (c_SH_OFF, c_SH_ON].
    localparam logic [c_TMR_W-1:0] c_ICG_LOAD = c_TMR_W'(ICG_TICKS - 1);
    localparam logic [c_TMR_W-1:0] c_SH_ON    = c_TMR_W'(ICG_TICKS - 1 - SH_DELAY);
    localparam logic [c_TMR_W-1:0] c_SH_OFF   = c_TMR_W'(ICG_TICKS - 1 - SH_DELAY - SH_TICKS);
    localparam logic [c_PIX_W-1:0] c_PIX_LAST = c_PIX_W'(N_PIXELS - 1);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_TMR_W-1:0] w_timer_nxt;
    logic [c_PIX_W-1:0] r_pix_idx;
    logic [c_PIX_W-1:0] w_pix_idx_nxt;
    logic               r_icg,       w_icg_nxt;
    logic               r_sh,        w_sh_nxt;
    logic               r_first,     w_first_nxt;
    logic               r_busy,      w_busy_nxt;
    logic               r_line_done, w_line_done_nxt;
    logic               r_overrun,   w_overrun_nxt;
    logic               w_in_pixels;
    logic               w_tick;
    logic               w_tick_rst;

    // Pixel-period boundaries. The ticker is held in reset outside PIXELS so
    // every line's first pixel period starts from a zero count.
    assign w_in_pixels = (r_state == PIXELS);
    assign w_tick_rst  = rst && w_in_pixels;

    ticker #(
        .N_TICKS (PIXEL_TICKS)
    ) u_pixel_ticker (
        .clk  (clk),
        .rst  (w_tick_rst),
        .en   (w_in_pixels),
        .tick (w_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_timer_nxt     = r_timer;
        w_pix_idx_nxt   = r_pix_idx;
        w_overrun_nxt   = r_overrun;
        w_icg_nxt       = 1'b0;
        w_sh_nxt        = 1'b0;
        w_first_nxt     = 1'b0;
        w_busy_nxt      = 1'b0;
        w_line_done_nxt = 1'b0;

        case (r_state)
            IDLE: begin
                w_pix_idx_nxt = '0;
                if (start) begin
                    w_state_nxt   = ICG;
                    w_timer_nxt   = c_ICG_LOAD;
                    w_overrun_nxt = 1'b0;
                    w_icg_nxt     = 1'b1;
                    w_busy_nxt    = 1'b1;
                end
            end
            ICG: begin
                w_busy_nxt = 1'b1;
                if (r_timer == '0) begin
                    w_state_nxt   = PIXELS;
                    w_pix_idx_nxt = '0;
                    w_first_nxt   = 1'b1;
                end else begin
                    w_timer_nxt = r_timer - c_TMR_W'(1);
                    w_icg_nxt   = 1'b1;
                end
            end
            PIXELS: begin
                w_busy_nxt = 1'b1;
                if (r_first && adc_busy) begin
                    w_overrun_nxt = 1'b1;
                end
                if (w_tick) begin
                    if (r_pix_idx == c_PIX_LAST) begin
                        w_state_nxt     = DONE;
                        w_line_done_nxt = 1'b1;
                    end else begin
                        w_pix_idx_nxt = r_pix_idx + c_PIX_W'(1);
                        w_first_nxt   = 1'b1;
                    end
                end
            end
            DONE: begin
                w_state_nxt   = IDLE;
                w_pix_idx_nxt = '0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        if (w_icg_nxt) begin
            w_sh_nxt = (w_timer_nxt <= c_SH_ON) && (w_timer_nxt > c_SH_OFF);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timer     <= '0;
            r_pix_idx   <= '0;
            r_icg       <= 1'b0;
            r_sh        <= 1'b0;
            r_first     <= 1'b0;
            r_busy      <= 1'b0;
            r_line_done <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_timer     <= w_timer_nxt;
            r_pix_idx   <= w_pix_idx_nxt;
            r_icg       <= w_icg_nxt;
            r_sh        <= w_sh_nxt;
            r_first     <= w_first_nxt;
            r_busy      <= w_busy_nxt;
            r_line_done <= w_line_done_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    assign icg       = r_icg;
    assign sh        = r_sh;
    assign pix_idx   = r_pix_idx;
    assign busy      = r_busy;
    assign line_done = r_line_done;
    assign overrun   = r_overrun;

    // The registered first-cycle strobe is qualified by the live adc_busy, so
    // the busy decision uses the same cycle the request would be issued in.
    assign acquire   = r_first && !adc_busy;

endmodule
`default_nettype wire

// File: tb/tb_ccd_readout_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ccd_readout_sequencer
//  Description : Self-checking bench for ccd_readout_sequencer with a
//                per-cycle expected-output scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ccd_readout_sequencer;

    localparam int c_NP = 4;
    localparam int c_PT = 8;
    localparam int c_IT = 10;
    localparam int c_SD = 2;
    localparam int c_ST = 3;
    localparam int c_LEN = c_IT + c_NP * c_PT + 1;   // busy cycles per line

    typedef struct {
        int         cyc;
        logic [5:0] flags;   // {icg, sh, acquire, line_done, busy, overrun}
        logic [1:0] idx;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       adc_busy;
    logic       icg;
    logic       sh;
    logic       acquire;
    logic [1:0] pix_idx;
    logic       busy;
    logic       line_done;
    logic       overrun;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   acq_seen = 0;
    bit   mon_en = 1'b0;
    exp_t sbq[$];
    exp_t m_e;

    ccd_readout_sequencer #(
        .N_PIXELS    (c_NP),
        .PIXEL_TICKS (c_PT),
        .ICG_TICKS   (c_IT),
        .SH_DELAY    (c_SD),
        .SH_TICKS    (c_ST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .adc_busy  (adc_busy),
        .icg       (icg),
        .sh        (sh),
        .acquire   (acquire),
        .pix_idx   (pix_idx),
        .busy      (busy),
        .line_done (line_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: cycles with a queued expectation are compared in
    // full, all other cycles must look idle.
    always @(negedge clk) begin
        if (mon_en) begin
            if (acquire === 1'b1) acq_seen++;
            while (sbq.size() > 0 && sbq[0].cyc < cyc) begin
                m_e = sbq.pop_front();
                total++; bad++;
                $display("FAIL sb_stale cyc=%0d got=unchecked want_cyc=%0d", cyc, m_e.cyc);
            end
            if (sbq.size() > 0 && sbq[0].cyc == cyc) begin
                m_e = sbq.pop_front();
                total++;
                if ({icg, sh, acquire, line_done, busy, overrun} !== m_e.flags) begin
                    bad++;
                    $display("FAIL line_flags cyc=%0d got=%b want=%b (icg sh acq done busy ovr)",
                             cyc, {icg, sh, acquire, line_done, busy, overrun}, m_e.flags);
                end
                total++;
                if (pix_idx !== m_e.idx) begin
                    bad++;
                    $display("FAIL line_pix_idx cyc=%0d got=%0d want=%0d", cyc, pix_idx, m_e.idx);
                end
            end else begin
                total++;
                if ({icg, sh, acquire, line_done, busy} !== 5'b0) begin
                    bad++;
                    $display("FAIL idle_flags cyc=%0d got=%b want=00000 (icg sh acq done busy)",
                             cyc, {icg, sh, acquire, line_done, busy});
                end
                total++;
                if (pix_idx !== 2'd0) begin
                    bad++;
                    $display("FAIL idle_pix_idx cyc=%0d got=%0d want=0", cyc, pix_idx);
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected timeline for a line whose start is driven in cycle t0.
    // ovr_rel is the relative cycle where adc_busy is held high (or -1).
    task automatic push_line(input int t0, input int ovr_rel);
        exp_t e;
        for (int r = 1; r <= c_LEN; r++) begin
            logic e_icg, e_sh, e_acq, e_done, e_ovr;
            int   idx;
            e_icg  = (r <= c_IT);
            e_sh   = (r >= 1 + c_SD) && (r <= c_SD + c_ST);
            e_acq  = (r > c_IT) && (r < c_LEN) && (((r - 1 - c_IT) % c_PT) == 0) && (r != ovr_rel);
            e_done = (r == c_LEN);
            e_ovr  = (ovr_rel > 0) && (r > ovr_rel);
            if (r <= c_IT)       idx = 0;
            else if (r == c_LEN) idx = c_NP - 1;
            else                 idx = (r - 1 - c_IT) / c_PT;
            e.cyc   = t0 + r;
            e.flags = {e_icg, e_sh, e_acq, e_done, 1'b1, e_ovr};
            e.idx   = 2'(idx);
            sbq.push_back(e);
        end
    endtask

    task automatic pulse_start(input int c);
        wait_until(c);
        start = 1'b1;
        wait_until(c + 1);
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; adc_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({icg, sh, acquire, line_done, busy, overrun} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b want=000000", {icg, sh, acquire, line_done, busy, overrun});
        end
        total++;
        if (pix_idx !== 2'd0) begin
            bad++;
            $display("FAIL reset_pix_idx got=%0d want=0", pix_idx);
        end
        rst = 1'b1;
        mon_en = 1'b1;
        wait_until(cyc + 2);
    endtask

    task automatic test_nominal;
        int t0, a0;
        t0 = cyc + 1;
        a0 = acq_seen;
        push_line(t0, -1);
        pulse_start(t0);
        wait_until(t0 + c_LEN + 3);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL nominal_overrun got=%b want=0", overrun);
        end
        total++;
        if (acq_seen - a0 !== c_NP) begin
            bad++;
            $display("FAIL nominal_acq_count got=%0d want=%0d", acq_seen - a0, c_NP);
        end
    endtask

    task automatic test_overrun;
        int t0, t1, a0;
        t0 = cyc + 1;
        a0 = acq_seen;
        push_line(t0, 19);
        pulse_start(t0);
        wait_until(t0 + 19);
        adc_busy = 1'b1;
        wait_until(t0 + 20);
        adc_busy = 1'b0;
        wait_until(t0 + c_LEN + 5);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got=%b want=1", overrun);
        end
        total++;
        if (acq_seen - a0 !== c_NP - 1) begin
            bad++;
            $display("FAIL overrun_acq_count got=%0d want=%0d", acq_seen - a0, c_NP - 1);
        end
        t1 = cyc + 1;
        push_line(t1, -1);
        pulse_start(t1);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got=%b want=0", overrun);
        end
        wait_until(t1 + c_LEN + 3);
    endtask

    task automatic test_ignored_start;
        int t0, a0;
        t0 = cyc + 1;
        a0 = acq_seen;
        push_line(t0, -1);
        pulse_start(t0);
        pulse_start(t0 + 5);
        pulse_start(t0 + c_LEN);
        wait_until(t0 + c_LEN + 12);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL ignored_no_restart busy got=%b want=0", busy);
        end
        total++;
        if (acq_seen - a0 !== c_NP) begin
            bad++;
            $display("FAIL ignored_acq_count got=%0d want=%0d", acq_seen - a0, c_NP);
        end
    endtask

    task automatic test_reset_mid;
        int t0;
        t0 = cyc + 1;
        push_line(t0, -1);
        pulse_start(t0);
        wait_until(t0 + 22);
        rst = 1'b0;
        while (sbq.size() > 0 && sbq[$].cyc >= t0 + 23) void'(sbq.pop_back());
        wait_until(t0 + 23);
        rst = 1'b1;
        total++;
        if ({icg, sh, acquire, line_done, busy, overrun} !== 6'b0 || pix_idx !== 2'd0) begin
            bad++;
            $display("FAIL midreset_outputs got=%b idx=%0d want=000000 idx=0",
                     {icg, sh, acquire, line_done, busy, overrun}, pix_idx);
        end
        push_line(t0 + 30, -1);
        pulse_start(t0 + 30);
        wait_until(t0 + 30 + c_LEN + 3);
    endtask

    task automatic test_back_to_back;
        int t0, a0;
        t0 = cyc + 1;
        a0 = acq_seen;
        push_line(t0, -1);
        push_line(t0 + c_LEN + 1, -1);
        pulse_start(t0);
        pulse_start(t0 + c_LEN + 1);
        wait_until(t0 + 2 * c_LEN + 5);
        total++;
        if (acq_seen - a0 !== 2 * c_NP) begin
            bad++;
            $display("FAIL b2b_acq_count got=%0d want=%0d", acq_seen - a0, 2 * c_NP);
        end
    endtask

    task automatic test_drain;
        wait_until(cyc + 5);
        total++;
        if (sbq.size() !== 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d pending want=0", sbq.size());
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_overrun();
        test_ignored_start();
        test_reset_mid();
        test_back_to_back();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
